dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 129 ++++++++++++
 tb/tb_dma_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Round-robin arbiter that hands one M2S DMA channel to N_REQ requesters, one
// descriptor at a time, and checks the observed beat count against the descriptor length.
module dma_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 64,
    parameter int BPT_W     = 32,
    parameter int BUS_WIDTH = 128,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0][BPT_W-1:0]   req_bpt,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [ADDR_W-1:0]             cmd_addr,
    output logic [BPT_W-1:0]              cmd_bpt,
    output logic [ID_W-1:0]               cmd_id,
    input  logic                          s_valid,
    input  logic                          s_ready,
    input  logic                          s_last,
    output logic                          done_valid,
    output logic [ID_W-1:0]               done_id,
    output logic                          done_err,
    output logic                          busy
);

    localparam int BYTES_PER_BEAT = BUS_WIDTH / 8;
    localparam logic [BPT_W-1:0] BPB = BPT_W'(BYTES_PER_BEAT);

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, id_q, grant_id;
    logic              grant_any;
    logic [ADDR_W-1:0] addr_q;
    logic [BPT_W-1:0]  bpt_q, expect_q, beats_q, beats_inc;
    logic [BPT_W-1:0]  grant_bpt, grant_expect;
    logic              err_q, beat;
    logic [N_REQ-1:0]  ready_c;
    int                idx;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    assign grant_bpt    = req_bpt[grant_id];
    assign grant_expect = grant_bpt / BPB
                        + {{(BPT_W-1){1'b0}}, ((grant_bpt % BPB) != '0)};
    assign beat         = (state == STREAM) && s_valid && s_ready;
    assign beats_inc    = (&beats_q) ? beats_q : beats_q + BPT_W'(1);

    always_comb begin
        state_nxt = state;
        ready_c   = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    ready_c[grant_id] = 1'b1;
                    state_nxt = (grant_bpt == '0) ? DONE : ISSUE;
                end
            end
            ISSUE:   if (cmd_ready) state_nxt = STREAM;
            STREAM:  if (beat && s_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            bpt_q    <= '0;
            expect_q <= '0;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        id_q     <= grant_id;
                        addr_q   <= req_addr[grant_id];
                        bpt_q    <= grant_bpt;
                        expect_q <= grant_expect;
                        beats_q  <= '0;
                        err_q    <= (grant_bpt == '0);
                    end
                end
                STREAM: begin
                    if (beat) begin
                        beats_q <= beats_inc;
                        if (s_last) err_q <= (beats_inc != expect_q);
                    end
                end
                DONE: rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                default: ;
            endcase
        end
    end

    // req_ready is combinational from IDLE, so hold it low while reset is asserted.
    assign req_ready  = areset ? '0 : ready_c;
    assign cmd_valid  = (state == ISSUE);
    assign cmd_addr   = addr_q;
    assign cmd_bpt    = bpt_q;
    assign cmd_id     = id_q;
    assign done_valid = (state == DONE);
    assign done_id    = done_valid ? id_q : '0;
    assign done_err   = done_valid & err_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dma_arbiter.sv
// Scenario bench for dma_arbiter: completions are predicted into a scoreboard queue
// and compared by a monitor; grant order, command timing and reset behaviour are checked inline.
module tb_dma_arbiter;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int BW = 32;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [N-1:0]          req_valid, req_ready;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][BW-1:0]  req_bpt;
    logic                  cmd_valid, cmd_ready;
    logic [AW-1:0]         cmd_addr;
    logic [BW-1:0]         cmd_bpt;
    logic [1:0]            cmd_id;
    logic                  s_valid, s_ready, s_last;
    logic                  done_valid, done_err, busy;
    logic [1:0]            done_id;

    typedef struct packed {
        logic [1:0] id;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    dma_arbiter #(.N_REQ(N), .ADDR_W(AW), .BPT_W(BW), .BUS_WIDTH(128)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_bpt(req_bpt),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_bpt(cmd_bpt), .cmd_id(cmd_id),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    function automatic logic [AW-1:0] addr_of(input int i);
        return 64'h0000_1000_0000_0000 + 64'h1000 * 64'(i + 1);
    endfunction

    // Completion scoreboard and single-grant invariant.
    always @(negedge aclk) begin
        exp_t e;
        if (!areset && done_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got id=%0d err=%0d, required no completion", done_id, done_err);
            end else begin
                e = sb.pop_front();
                if ({done_id, done_err} !== {e.id, e.err}) begin
                    miscompares++;
                    $display("FAIL done_report: got id=%0d err=%0d, required id=%0d err=%0d",
                             done_id, done_err, e.id, e.err);
                end
            end
        end
        if (|req_ready) begin
            vectors++;
            if ($countones(req_ready) != 1 || busy) begin
                miscompares++;
                $display("FAIL grant_onehot: got req_ready=%b busy=%b, required one-hot and idle", req_ready, busy);
            end
        end
    end

    task automatic nxt();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_grant(output logic [1:0] id, output bit ok);
        id = '0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge aclk);
            if (|req_ready) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (req_ready[i]) id = 2'(i);
            end
        end
    endtask

    // Drives n beats with s_last on the n-th; gaps insert non-beat noise cycles.
    task automatic send_beats(input int n, input bit gaps);
        int g;
        for (int b = 1; b <= n; b++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                s_valid = 1'b1; s_ready = 1'b0; s_last = 1'b1;
                nxt();
            end
            s_ready = 1'b1;
            s_valid = 1'b1;
            s_last  = (b == n);
            nxt();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        req_valid = '1;
        cmd_ready = 1'b1;
        s_valid = 1'b0; s_ready = 1'b1; s_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = addr_of(i);
            req_bpt[i]  = 32'd64;
        end
        repeat (2) @(negedge aclk);
        vectors++;
        if ({req_ready, cmd_valid, cmd_addr, cmd_bpt, cmd_id, done_valid, done_id, done_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req_ready=%b cmd_valid=%b busy=%b, required all zero",
                     req_ready, cmd_valid, busy);
        end
        nxt();
        req_valid = '0;
        areset    = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] id;
        bit         ok;
        logic [1:0] exp_id;
        nxt();
        req_valid = '1;
        for (int t = 0; t < 4; t++) begin
            exp_id = 2'(t % 3);
            wait_grant(id, ok);
            vectors++;
            if (!ok || id !== exp_id) begin
                miscompares++;
                $display("FAIL rr_grant: got id=%0d (seen=%0d), required id=%0d", id, ok, exp_id);
            end
            sb.push_back('{id: exp_id, err: 1'b0});
            nxt();
            @(negedge aclk);
            vectors++;
            if ({cmd_valid, cmd_id, cmd_addr, cmd_bpt} !== {1'b1, exp_id, addr_of(int'(exp_id)), 32'd64}) begin
                miscompares++;
                $display("FAIL cmd_issue: got v=%b id=%0d addr=%h bpt=%0d, required v=1 id=%0d addr=%h bpt=64",
                         cmd_valid, cmd_id, cmd_addr, cmd_bpt, exp_id, addr_of(int'(exp_id)));
            end
            nxt();
            send_beats(4, 1'b0);
            if (t == 3) req_valid = '0;
            @(negedge aclk);
            vectors++;
            if (done_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL done_latency: got done_valid=%b, required 1", done_valid);
            end
        end
    endtask

    task automatic test_gaps();
        logic [1:0] id;
        bit         ok;
        nxt();
        req_valid  = 3'b100;
        req_bpt[2] = 32'd40;
        wait_grant(id, ok);
        vectors++;
        if (!ok || id !== 2'd2) begin
            miscompares++;
            $display("FAIL gaps_grant: got id=%0d (seen=%0d), required id=2", id, ok);
        end
        sb.push_back('{id: 2'd2, err: 1'b0});
        nxt();
        req_valid = '0;
        nxt();
        send_beats(3, 1'b1);
        req_bpt[2] = 32'd64;
    endtask

    task automatic test_len_err();
        logic [1:0] id;
        bit         ok;
        nxt();
        for (int r = 0; r < 2; r++) begin
            req_valid = 3'b001;
            wait_grant(id, ok);
            vectors++;
            if (!ok || id !== 2'd0) begin
                miscompares++;
                $display("FAIL len_err_grant: got id=%0d (seen=%0d), required id=0", id, ok);
            end
            sb.push_back('{id: 2'd0, err: 1'b1});
            nxt();
            req_valid = '0;
            nxt();
            send_beats((r == 0) ? 2 : 6, 1'b0);
            nxt();
            @(negedge aclk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after_err: got busy=%b, required 0", busy);
            end
            nxt();
        end
    endtask

    task automatic test_zero_bpt();
        logic [1:0] id;
        bit         ok;
        req_bpt[1] = '0;
        req_valid  = 3'b010;
        wait_grant(id, ok);
        vectors++;
        if (!ok || id !== 2'd1) begin
            miscompares++;
            $display("FAIL zero_grant: got id=%0d (seen=%0d), required id=1", id, ok);
        end
        sb.push_back('{id: 2'd1, err: 1'b1});
        nxt();
        req_valid = '0;
        @(negedge aclk);
        vectors++;
        if ({cmd_valid, done_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_bpt: got cmd_valid=%b done_valid=%b, required 0 and 1", cmd_valid, done_valid);
        end
        nxt();
        req_bpt[1] = 32'd64;
    endtask

    task automatic test_cmd_stall();
        logic [1:0] id;
        bit         ok;
        nxt();
        cmd_ready = 1'b0;
        req_valid = '1;
        wait_grant(id, ok);
        vectors++;
        if (!ok || id !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_grant: got id=%0d (seen=%0d), required id=2", id, ok);
        end
        sb.push_back('{id: 2'd2, err: 1'b0});
        nxt();
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            vectors++;
            if ({cmd_valid, cmd_addr, cmd_bpt, cmd_id, req_ready} !== {1'b1, addr_of(2), 32'd64, 2'd2, 3'b000}) begin
                miscompares++;
                $display("FAIL cmd_stall: cycle %0d got v=%b addr=%h bpt=%0d id=%0d req_ready=%b, required held command and no grants",
                         k, cmd_valid, cmd_addr, cmd_bpt, cmd_id, req_ready);
            end
            nxt();
        end
        cmd_ready = 1'b1;
        nxt();
        send_beats(4, 1'b0);
        req_valid = 3'b110;
    endtask

    task automatic test_reset_mid_stream();
        logic [1:0] id;
        bit         ok;
        wait_grant(id, ok);
        vectors++;
        if (!ok || id !== 2'd1) begin
            miscompares++;
            $display("FAIL pre_reset_grant: got id=%0d (seen=%0d), required id=1", id, ok);
        end
        nxt();
        req_valid = '0;
        nxt();
        s_valid = 1'b1; s_last = 1'b0;
        nxt();
        areset = 1'b1;
        #1;
        vectors++;
        if ({req_ready, cmd_valid, cmd_addr, cmd_bpt, cmd_id, done_valid, done_id, done_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_stream: got cmd_valid=%b cmd_addr=%h done_valid=%b busy=%b, required all zero",
                     cmd_valid, cmd_addr, done_valid, busy);
        end
        s_valid   = 1'b0;
        req_valid = '1;
        repeat (3) nxt();
        areset = 1'b0;
        wait_grant(id, ok);
        vectors++;
        if (!ok || id !== 2'd0) begin
            miscompares++;
            $display("FAIL first_after_reset: got id=%0d (seen=%0d), required id=0", id, ok);
        end
        sb.push_back('{id: 2'd0, err: 1'b0});
        nxt();
        req_valid = '0;
        nxt();
        send_beats(4, 1'b0);
        repeat (2) nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_gaps();
        test_len_err();
        test_zero_bpt();
        test_cmd_stall();
        test_reset_mid_stream();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending completions, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
